// File: rtl/regseq_pkg.sv
// Shared opcodes, FSM encoding and opcode-to-strobe decode for register_sequencer.
// OP_INCW is only accepted when REGSEQ_WRAP_DETECT_EN is defined.
package regseq_pkg;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_INCW = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic clr;
    logic l;
    logic inc;
    logic dec;
    logic shl;
    logic shr;
  } strobe_t;

  // INC_TO_WRAP drives the ordinary INC strobe; reserved opcodes decode to nothing.
  function automatic strobe_t op_strobes(input logic [2:0] op);
    strobe_t s;
    s = '0;
    case (op)
      OP_CLR:  s.clr = 1'b1;
      OP_LOAD: s.l   = 1'b1;
      OP_INC:  s.inc = 1'b1;
      OP_DEC:  s.dec = 1'b1;
      OP_SHL:  s.shl = 1'b1;
      OP_SHR:  s.shr = 1'b1;
      OP_INCW: s.inc = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/regseq_serializer.sv
// N-bit load / shift-right register; sout is the bit presented on the current step.
// Zeros fill from the top so long bursts shift in zeros after the N loaded bits.
module regseq_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic [N-1:0] q,
  output logic         sout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[N-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/register_sequencer.sv
// Command-driven strobe sequencer for the load/inc/dec/shift wrap register.
// Optional macro REGSEQ_WRAP_DETECT_EN adds QI/wrap ports and the INC_TO_WRAP opcode.
//
// Handshake: a command transfers on a rising edge of C where cmd_valid and
// cmd_ready are both high; cmd_* must be stable while cmd_valid is high, and
// cmd_ready never depends combinationally on cmd_valid.
module register_sequencer
  import regseq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          C,
  input  logic          R,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [N-1:0]  cmd_arg,
  input  logic [N-1:0]  cmd_lim,
  input  logic [CW-1:0] cmd_cnt,
  input  logic          abort,
  output logic          done,
  output logic          CLR,
  output logic          L,
  output logic          INC,
  output logic          DEC,
  output logic          SHL,
  output logic          SHR,
  output logic [N-1:0]  D,
  output logic [N-1:0]  W,
`ifdef REGSEQ_WRAP_DETECT_EN
  input  logic [N-1:0]  QI,
  output logic          wrap,
`endif
  output logic [1:0]    state_dbg
);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  lim_q, lim_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          ready_q;
  logic          accept;
  logic          in_exec;
  logic          is_shift;
  logic [N-1:0]  s_q;
  logic          s_bit;
  strobe_t       strb;

  // ready_q keeps cmd_ready low until the first edge after reset releases.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign cmd_ready = ready_q & (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign in_exec   = (state_q == ST_EXEC);
  assign is_shift  = (op_q == OP_SHL) || (op_q == OP_SHR);

  regseq_serializer #(.N(N)) u_ser (
    .clk   (C),
    .rst   (R),
    .load  (accept),
    .shift (in_exec & is_shift),
    .din   (cmd_arg),
    .q     (s_q),
    .sout  (s_bit)
  );

`ifdef REGSEQ_WRAP_DETECT_EN
  logic wrap_hit;
  assign wrap_hit = in_exec &
                    ((((op_q == OP_INC) || (op_q == OP_INCW)) && (QI >= lim_q)) ||
                     ((op_q == OP_DEC) && (QI <= lim_q)));
  assign wrap = wrap_hit;
`endif

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CLR;
      lim_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lim_q   <= lim_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lim_d   = lim_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          lim_d = cmd_lim;
          rem_d = cmd_cnt;
          case (cmd_op)
            OP_CLR, OP_LOAD: begin
              rem_d   = CW'(1);
              state_d = ST_EXEC;
            end
            OP_INC, OP_DEC, OP_SHL, OP_SHR: begin
              state_d = (cmd_cnt == '0) ? ST_DONE : ST_EXEC;
            end
`ifdef REGSEQ_WRAP_DETECT_EN
            OP_INCW: begin
              state_d = ST_EXEC;
            end
`endif
            default: begin
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_EXEC: begin
        // A zero count only reaches EXEC for INC_TO_WRAP, where it means unbounded.
        if (rem_q != '0) begin
          rem_d = rem_q - CW'(1);
        end
        if (abort || (rem_q == CW'(1))) begin
          state_d = ST_DONE;
        end
`ifdef REGSEQ_WRAP_DETECT_EN
        if (wrap_hit && (op_q == OP_INCW)) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign strb = in_exec ? op_strobes(op_q) : '0;
  assign CLR  = strb.clr;
  assign L    = strb.l;
  assign INC  = strb.inc;
  assign DEC  = strb.dec;
  assign SHL  = strb.shl;
  assign SHR  = strb.shr;

  // Replicating the serial bit makes it land on D[0] for SHL and D[N-1] for SHR.
  always_comb begin
    D = '0;
    if (in_exec) begin
      if (op_q == OP_LOAD) begin
        D = s_q;
      end else if (is_shift) begin
        D = {N{s_bit}};
      end
    end
  end

  assign W         = lim_q;
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Directed bench for register_sequencer (N=4, CW=4): vector table plus hand sequences
// for reset, abort and reset-mid-burst; a behavioural wrap register follows the strobes.
module tb_register_sequencer;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] cmd_lim = 4'd0;
  logic [3:0] cmd_cnt = 4'd0;
  logic       abort = 1'b0;
  logic       done;
  logic       CLR, L, INC, DEC, SHL, SHR;
  logic [3:0] D, W;
  logic [1:0] state_dbg;
  logic [3:0] q_m = 4'd0;
`ifdef REGSEQ_WRAP_DETECT_EN
  logic       wrap;
`endif

  int checks = 0;
  int errors = 0;

  register_sequencer #(.N(4), .CW(4)) dut (
    .C         (C),
    .R         (R),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_lim   (cmd_lim),
    .cmd_cnt   (cmd_cnt),
    .abort     (abort),
    .done      (done),
    .CLR       (CLR),
    .L         (L),
    .INC       (INC),
    .DEC       (DEC),
    .SHL       (SHL),
    .SHR       (SHR),
    .D         (D),
    .W         (W),
`ifdef REGSEQ_WRAP_DETECT_EN
    .QI        (q_m),
    .wrap      (wrap),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 C = ~C;

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

  // Behavioural wrap register fed by the strobes, sampled mid-cycle.
  always @(negedge C) begin
    if (CLR)      q_m <= 4'd0;
    else if (L)   q_m <= D;
    else if (INC) q_m <= (q_m >= W) ? 4'd0 : q_m + 4'd1;
    else if (DEC) q_m <= (q_m == 4'd0) ? W : q_m - 4'd1;
    else if (SHL) q_m <= {q_m[2:0], D[0]};
    else if (SHR) q_m <= {D[3], q_m[3:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  arg;
    logic [3:0]  lim;
    logic [3:0]  cnt;
    int          abort_after;
    logic [5:0]  exp_strobe;   // {CLR,L,INC,DEC,SHL,SHR}
    int          exp_steps;
    logic [15:0] exp_sin;      // per-step shift-in bit, step 0 at bit 0
    logic [3:0]  exp_d;
    logic        check_q;
    logic [3:0]  exp_q;
  } vec_t;

  vec_t vecs[13];

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge C);
    check({name, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] arg, input logic [3:0] lim,
                       input logic [3:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_lim   = lim;
    cmd_cnt   = cnt;
    @(posedge C);
    #1;
    cmd_valid = 1'b0;
    cmd_cnt   = 4'd0;
  endtask

  // driver + per-cycle checks for one table entry
  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    logic [5:0] s;
    int steps;
    bit seen_done;
    nm = $sformatf("v%0d", idx);
    wait_ready(nm);
    issue(v.op, v.arg, v.lim, v.cnt);
    steps = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      @(negedge C);
      s = {CLR, L, INC, DEC, SHL, SHR};
      if (done) begin
        seen_done = 1'b1;
        check({nm, "_done_strobes"}, 32'(s), 32'd0);
        check({nm, "_done_ready"}, 32'(cmd_ready), 32'd0);
      end else if (s == 6'd0) begin
        check({nm, "_gap"}, 32'(s), 32'(v.exp_strobe));
      end else begin
        check({nm, "_strobe"}, 32'(s), 32'(v.exp_strobe));
        check({nm, "_w"}, 32'(W), 32'(v.lim));
        check({nm, "_busy_ready"}, 32'(cmd_ready), 32'd0);
        if (v.op == 3'd4 || v.op == 3'd5) begin
          if (steps < 16) check({nm, "_sin"}, 32'(D), 32'({4{v.exp_sin[steps]}}));
        end else begin
          check({nm, "_d"}, 32'(D), 32'(v.exp_d));
        end
        steps++;
        if (v.abort_after != 0 && steps == v.abort_after) begin
          abort = 1'b1;
          @(posedge C);
          #1;
          abort = 1'b0;
        end
      end
    end
    check({nm, "_done_seen"}, 32'(seen_done), 32'd1);
    check({nm, "_steps"}, 32'(steps), 32'(v.exp_steps));
    @(negedge C);
    check({nm, "_done_pulse"}, 32'(done), 32'd0);
    check({nm, "_ready_after"}, 32'(cmd_ready), 32'd1);
    if (v.check_q) check({nm, "_q"}, 32'(q_m), 32'(v.exp_q));
  endtask

  initial begin
    //              op    arg    lim   cnt  ab  strobe     st sin     d      chk   q
    vecs[0]  = '{3'd0, 4'h0, 4'd0, 4'd5, 0, 6'b100000, 1, 16'h0, 4'h0, 1'b1, 4'h0};
    vecs[1]  = '{3'd1, 4'hA, 4'd3, 4'd7, 0, 6'b010000, 1, 16'h0, 4'hA, 1'b1, 4'hA};
    vecs[2]  = '{3'd1, 4'h8, 4'd9, 4'd0, 0, 6'b010000, 1, 16'h0, 4'h8, 1'b1, 4'h8};
    vecs[3]  = '{3'd2, 4'h0, 4'd9, 4'd3, 0, 6'b001000, 3, 16'h0, 4'h0, 1'b1, 4'h1};
    vecs[4]  = '{3'd0, 4'h0, 4'd0, 4'd0, 0, 6'b100000, 1, 16'h0, 4'h0, 1'b1, 4'h0};
    vecs[5]  = '{3'd4, 4'h6, 4'd0, 4'd4, 0, 6'b000010, 4, 16'h6, 4'h0, 1'b1, 4'h6};
    vecs[6]  = '{3'd0, 4'h0, 4'd0, 4'd0, 0, 6'b100000, 1, 16'h0, 4'h0, 1'b1, 4'h0};
    vecs[7]  = '{3'd5, 4'h6, 4'd0, 4'd4, 0, 6'b000001, 4, 16'h6, 4'h0, 1'b1, 4'h6};
    vecs[8]  = '{3'd3, 4'h0, 4'd5, 4'd10, 2, 6'b000100, 2, 16'h0, 4'h0, 1'b0, 4'h0};
    vecs[9]  = '{3'd2, 4'h0, 4'd2, 4'd0, 0, 6'b000000, 0, 16'h0, 4'h0, 1'b0, 4'h0};
    vecs[10] = '{3'd7, 4'h5, 4'd2, 4'd3, 0, 6'b000000, 0, 16'h0, 4'h0, 1'b0, 4'h0};
    vecs[11] = '{3'd4, 4'hB, 4'd0, 4'd6, 0, 6'b000010, 6, 16'h000B, 4'h0, 1'b1, 4'h4};
    vecs[12] = '{3'd3, 4'h0, 4'd3, 4'd2, 0, 6'b000100, 2, 16'h0, 4'h0, 1'b0, 4'h0};

    // reset state
    repeat (2) @(negedge C);
    check("rst_strobes", 32'({CLR, L, INC, DEC, SHL, SHR}), 32'd0);
    check("rst_d", 32'(D), 32'd0);
    check("rst_w", 32'(W), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    R = 1'b0;
    #1;
    check("rst_release_ready", 32'(cmd_ready), 32'd0);
    @(negedge C);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_state", 32'(state_dbg), 32'd0);

    // abort held in IDLE must not matter
    abort = 1'b1;
    @(negedge C);
    check("idle_abort_ready", 32'(cmd_ready), 32'd1);
    abort = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // reset during an SHR cnt=5 burst
    wait_ready("mid_rst");
    issue(3'd5, 4'h6, 4'd0, 4'd5);
    @(negedge C);
    check("mid_rst_shr1", 32'(SHR), 32'd1);
    @(negedge C);
    check("mid_rst_shr2", 32'(SHR), 32'd1);
    #1;
    R = 1'b1;
    #1;
    check("mid_rst_strobes", 32'({CLR, L, INC, DEC, SHL, SHR}), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge C);
      check("mid_rst_hold_done", 32'(done), 32'd0);
    end
    R = 1'b0;
    @(negedge C);
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_recover", 32'(cmd_ready), 32'd1);

    // sequencer usable again after the abandoned burst
    run_vec(13, '{3'd1, 4'h3, 4'd7, 4'd0, 0, 6'b010000, 1, 16'h0, 4'h3, 1'b1, 4'h3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_sequencer.md
Name: register_sequencer

Overview:
Command-driven controller for the team's parameterised load/inc/dec/shift register with a wrap limit.
- Accepts one command at a time over a valid/ready handshake.
- Expands each command into a burst of single-cycle control strobes (CLR/L/INC/DEC/SHL/SHR) plus data D and limit W.
- Serialises a data word into the register's shift-in bit for multi-step shifts.
- Reports completion with a one-cycle done pulse.

Parameters:
- N, 4, register width (matches the driven register; N>=2).
- CW, 4, repeat-count width; max burst = 2^CW-1.

Ports:
- C  input  1  clock, all state on posedge.
- R  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode: 0 CLR, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6-7 reserved.
- cmd_arg  input  N  load value, or shift-in bit stream (LSB first).
- cmd_lim  input  N  wrap limit for INC/DEC.
- cmd_cnt  input  CW  number of INC/DEC/SHL/SHR steps.
- abort  input  1  terminate the running burst.
- done  output  1  one-cycle pulse when a command finishes.
- CLR, L, INC, DEC, SHL, SHR  output  1 each  register control strobes.
- D  output  N  register data input.
- W  output  N  register wrap limit.

Behaviour:
- Reset (R high, asynchronous): state IDLE, all strobes 0, D=0, W=0, done=0, cmd_ready=0 while R is high. cmd_ready=1 from the first clock edge after R falls.
- States: IDLE, EXEC, DONE. All outputs are decoded from registered state (Moore); no combinational path from cmd_* to strobes.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready: latch op, arg into serial register S, lim, and remaining = cmd_cnt.
  - CLR/LOAD: go to EXEC with remaining forced to 1; cmd_cnt is ignored.
  - INC/DEC/SHL/SHR with cmd_cnt=0: go to DONE; no strobe is issued.
  - Reserved opcodes: go to DONE; no strobe is issued.
  - Otherwise go to EXEC.
- EXEC:
  - cmd_ready=0. Exactly one strobe is high per cycle (one-hot, matching op). W = latched lim throughout.
  - LOAD: D = latched arg.
  - SHL/SHR: D = {N{S[0]}}, so the register's shift-in bit (D[0] for SHL, D[N-1] for SHR) is S[0]. S shifts right by one each step, zero-filled. When cmd_cnt>N, zeros are shifted in after the N arg bits.
  - INC/DEC/CLR: D = 0.
  - remaining decrements every cycle. When remaining==1, next state is DONE.
  - First strobe appears the cycle after acceptance. A burst of k steps gives k consecutive strobe cycles, then done on cycle k+1.
- abort:
  - Sampled only in EXEC. When high at an edge, the next state is DONE; strobes already issued stand.
  - abort in IDLE or DONE has no effect.
- DONE: done=1 for one cycle, all strobes 0, cmd_ready=0, then IDLE. Back-to-back commands are therefore spaced by at least one idle-accept cycle.
- Reset mid-burst: burst abandoned, no done pulse, strobes 0 immediately (asynchronous).
- Counter width: remaining is CW bits; no wrap, because it stops at 1.

Optional Feature:
- Macro: REGSEQ_WRAP_DETECT_EN.
- Defined: adds input QI[N-1:0] (register's Q) and output wrap (1 bit).
  - wrap pulses for one cycle in the same cycle as an INC strobe where QI>=W, or a DEC strobe where QI<=W, i.e. the step on which the register wraps.
  - Additionally, cmd_op 6 (INC_TO_WRAP) runs INC steps until wrap, then DONE on the following cycle. cmd_cnt bounds the run: a count of 0 means unlimited.
- Undefined: no QI or wrap ports; opcode 6 remains reserved.

Decomposition:
- Package regseq_pkg: opcode localparams (OP_CLR..OP_SHR, OP_INCW), state encoding (ST_IDLE, ST_EXEC, ST_DONE), op-to-strobe decode function.
- One sub-module, regseq_serializer: N-bit load/shift-right register with a serial out bit (S), load/shift enables.

Test Plan (N=4, CW=4):
- Reset then idle: R pulse -> all strobes 0, D=0, W=0, cmd_ready=0 during R, 1 on the cycle after R falls.
- LOAD arg=4'b1010: L high for exactly 1 cycle with D=4'b1010, done the next cycle; cmd_cnt=7 is ignored.
- INC cnt=3 lim=4'd9: INC high 3 consecutive cycles with W=9, then done; with the real register starting at 8, Q goes 9, 0, 1.
- SHL cnt=4 arg=4'b0110: D[0] sequence 0, 1, 1, 0 on 4 SHL cycles; register from 0 ends at 4'b0110. SHR cnt=4 with the same arg: D[3] sequence 0, 1, 1, 0; register ends at 4'b0110.
- DEC cnt=10 with abort asserted after the 2nd strobe: exactly 2 DEC strobes, then done, then cmd_ready.
- cnt=0 INC, reserved op 7, and reset asserted mid-burst of SHR cnt=5: the first two give done with no strobe; the reset case drops strobes immediately and gives no done.
